i2c_bit_engine: RTL and testbench

//  Bit-level I2C master engine directly downstream of the WISHBONE register/byte layer.

---
 rtl/i2c_pkg.sv | 48 ++++
 rtl/i2c_line_sync.sv | 40 ++++
 rtl/i2c_bit_engine.sv | 147 ++++++++++++++
 tb/tb_i2c_bit_engine.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// i2c_pkg: shared types for the I2C bit engine.
//   cmd_e       - bus primitive requested by the byte layer
//   state_e     - bit-engine FSM state; the A..D phases of each primitive use consecutive codes
//   phase_lines - {scl, sda} release pattern driven in a given state (1 = released)
package i2c_pkg;

  localparam int PRER_W_DEF = 16;

  typedef enum logic [2:0] {
    NOP   = 3'd0,
    START = 3'd1,
    STOP  = 3'd2,
    WRITE = 3'd3,
    READ  = 3'd4
  } cmd_e;

  typedef enum logic [4:0] {
    IDLE    = 5'd0,
    START_A = 5'd1,  START_B = 5'd2,  START_C = 5'd3,  START_D = 5'd4,
    STOP_A  = 5'd5,  STOP_B  = 5'd6,  STOP_C  = 5'd7,  STOP_D  = 5'd8,
    WR_A    = 5'd9,  WR_B    = 5'd10, WR_C    = 5'd11, WR_D    = 5'd12,
    RD_A    = 5'd13, RD_B    = 5'd14, RD_C    = 5'd15, RD_D    = 5'd16
  } state_e;

  // IDLE keeps whatever the last primitive left on the bus (e.g. SCL low
  // after START), so a held bus is never released by accident.
  function automatic logic [1:0] phase_lines(state_e st, logic din, logic [1:0] cur);
    case (st)
      START_A:          phase_lines = {cur[1], 1'b1};
      START_B:          phase_lines = 2'b11;
      START_C:          phase_lines = 2'b10;
      START_D:          phase_lines = 2'b00;
      STOP_A:           phase_lines = 2'b00;
      STOP_B, STOP_C:   phase_lines = 2'b10;
      STOP_D:           phase_lines = 2'b11;
      WR_A, WR_D:       phase_lines = {1'b0, din};
      WR_B, WR_C:       phase_lines = {1'b1, din};
      RD_A, RD_D:       phase_lines = 2'b01;
      RD_B, RD_C:       phase_lines = 2'b11;
      default:          phase_lines = cur;
    endcase
  endfunction

  function automatic logic is_phase_d(state_e st);
    return (st == START_D) || (st == STOP_D) || (st == WR_D) || (st == RD_D);
  endfunction

endpackage

// File: rtl/i2c_line_sync.sv
// i2c_line_sync: multi-flop synchronizer for SCL/SDA plus bus START/STOP detection.
//   clk_i, rst_ni      clock / async active-low reset
//   scl_i, sda_i       raw pad inputs
//   scl_s_o, sda_s_o   synchronized line levels (reset to idle-high)
//   start_o, stop_o    1-cycle: SDA fell / rose while SCL high (synchronized domain)
module i2c_line_sync #(
  parameter int SYNC_STG = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic scl_i,
  input  logic sda_i,
  output logic scl_s_o,
  output logic sda_s_o,
  output logic start_o,
  output logic stop_o
);

  logic [SYNC_STG-1:0] scl_sync_q;
  logic [SYNC_STG-1:0] sda_sync_q;
  logic                sda_prev_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STG-2:0], scl_i};
      sda_sync_q <= {sda_sync_q[SYNC_STG-2:0], sda_i};
      sda_prev_q <= sda_sync_q[SYNC_STG-1];
    end
  end

  assign scl_s_o = scl_sync_q[SYNC_STG-1];
  assign sda_s_o = sda_sync_q[SYNC_STG-1];
  assign start_o = scl_s_o &  sda_prev_q & ~sda_s_o;
  assign stop_o  = scl_s_o & ~sda_prev_q &  sda_s_o;

endmodule

// File: rtl/i2c_bit_engine.sv
// i2c_bit_engine: bit-level I2C master; one START/STOP/WRITE/READ primitive per request.
//   wb_clk_i, arst_i          clock / async active-low reset
//   ena                       core enable; 0 freezes counter and FSM
//   clk_cnt                   prescale reload; each phase lasts clk_cnt+1 cycles
//   cmd, cmd_valid, din       request (held until cmd_ack or al)
//   cmd_ack, dout             completion pulse, READ result
//   busy, al                  bus busy flag, arbitration-lost pulse
//   scl/sda_pad_i/_o/_padoen_o  open-drain pads (pad_o tied 0, padoen 1 = release)
//
// state       | meaning
// IDLE        | waiting for a request, lines hold last levels
// START_A..D  | (scl,sda): (prev,1) (1,1) (1,0) (0,0)
// STOP_A..D   | (0,0) (1,0) (1,0) (1,1)
// WR_A..D     | (0,din) (1,din) (1,din) (0,din)
// RD_A..D     | (0,1) (1,1) (1,1) (0,1); dout sampled leaving RD_B
module i2c_bit_engine
  import i2c_pkg::*;
#(
  parameter int PRER_W   = PRER_W_DEF,
  parameter int SYNC_STG = 2
) (
  input  logic              wb_clk_i,
  input  logic              arst_i,
  input  logic              ena,
  input  logic [PRER_W-1:0] clk_cnt,
  input  logic [2:0]        cmd,
  input  logic              cmd_valid,
  input  logic              din,
  output logic              cmd_ack,
  output logic              dout,
  output logic              busy,
  output logic              al,
  input  logic              scl_pad_i,
  output logic              scl_pad_o,
  output logic              scl_padoen_o,
  input  logic              sda_pad_i,
  output logic              sda_pad_o,
  output logic              sda_padoen_o
);

  logic scl_s, sda_s, start_det, stop_det;

  i2c_line_sync #(.SYNC_STG(SYNC_STG)) u_sync (
    .clk_i   (wb_clk_i),
    .rst_ni  (arst_i),
    .scl_i   (scl_pad_i),
    .sda_i   (sda_pad_i),
    .scl_s_o (scl_s),
    .sda_s_o (sda_s),
    .start_o (start_det),
    .stop_o  (stop_det)
  );

  state_e              state_q, state_d;
  logic [PRER_W-1:0]   cnt_q, cnt_d;
  logic                scl_oen_q, sda_oen_q;
  logic [SYNC_STG-1:0] scl_oen_dly_q;
  logic                cmd_ack_q, cmd_ack_d;
  logic                dout_q, dout_d;
  logic                busy_q, busy_d;
  logic                al_q, al_d;
  logic [1:0]          lines_d;
  logic                stretch, run, in_stop, arb_sda;

  // Only treat low SCL as stretching once our release has had time to pass
  // the synchronizer; otherwise every SCL rise would look like a stretch.
  assign stretch = scl_oen_q & (&scl_oen_dly_q) & ~scl_s;
  assign run     = ena & ~stretch;
  assign in_stop = (state_q == STOP_A) || (state_q == STOP_B) ||
                   (state_q == STOP_C) || (state_q == STOP_D);
  assign arb_sda = sda_oen_q & scl_s & ~sda_s &
                   ((state_q == START_B) || (state_q == START_C) ||
                    (state_q == WR_B)    || (state_q == WR_C));
  assign al_d    = ena & (state_q != IDLE) & (arb_sda | (stop_det & ~in_stop));
  assign busy_d  = start_det ? 1'b1 : (stop_det ? 1'b0 : busy_q);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cmd_ack_d = 1'b0;
    dout_d    = dout_q;
    if (state_q == IDLE) begin
      if (ena && cmd_valid) begin
        case (cmd)
          START:   state_d = START_A;
          STOP:    state_d = STOP_A;
          WRITE:   state_d = WR_A;
          READ:    state_d = RD_A;
          default: state_d = IDLE;
        endcase
      end
      if (state_d != IDLE) cnt_d = clk_cnt;
    end else if (al_d) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else if (run) begin
      if (cnt_q == '0) begin
        cnt_d = clk_cnt;
        if (state_q == RD_B) dout_d = sda_s;
        if (is_phase_d(state_q)) begin
          state_d   = IDLE;
          cnt_d     = '0;
          cmd_ack_d = 1'b1;
        end else begin
          state_d = state_e'(state_q + 5'd1);
        end
      end else begin
        cnt_d = cnt_q - PRER_W'(1);
      end
    end
    lines_d = al_d ? 2'b11 : phase_lines(state_d, din, {scl_oen_q, sda_oen_q});
  end

  always_ff @(posedge wb_clk_i or negedge arst_i) begin
    if (!arst_i) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      scl_oen_q     <= 1'b1;
      sda_oen_q     <= 1'b1;
      scl_oen_dly_q <= '1;
      cmd_ack_q     <= 1'b0;
      dout_q        <= 1'b0;
      busy_q        <= 1'b0;
      al_q          <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      scl_oen_q     <= lines_d[1];
      sda_oen_q     <= lines_d[0];
      scl_oen_dly_q <= {scl_oen_dly_q[SYNC_STG-2:0], scl_oen_q};
      cmd_ack_q     <= cmd_ack_d;
      dout_q        <= dout_d;
      busy_q        <= busy_d;
      al_q          <= al_d;
    end
  end

  assign cmd_ack      = cmd_ack_q;
  assign dout         = dout_q;
  assign busy         = busy_q;
  assign al           = al_q;
  assign scl_pad_o    = 1'b0;
  assign sda_pad_o    = 1'b0;
  assign scl_padoen_o = scl_oen_q;
  assign sda_padoen_o = sda_oen_q;

endmodule

// File: tb/tb_i2c_bit_engine.sv
// tb_i2c_bit_engine: directed bench for i2c_bit_engine with pulled-up SCL/SDA
// lines and a bench-controlled "other device" that can hold either line low.
module tb_i2c_bit_engine;
  import i2c_pkg::*;

  logic        wb_clk_i = 1'b0;
  logic        arst_i, ena, cmd_valid, din;
  logic [15:0] clk_cnt;
  logic [2:0]  cmd;
  logic        cmd_ack, dout, busy, al;
  logic        scl_pad_i, scl_pad_o, scl_padoen_o;
  logic        sda_pad_i, sda_pad_o, sda_padoen_o;
  logic        ext_scl, ext_sda;

  int n_cmp = 0;
  int n_mis = 0;

  int   n;
  logic got_ack, got_al, sda_fell_hi, wr_stable, ack_seen;

  // Wired-AND bus with pull-ups.
  assign scl_pad_i = (scl_padoen_o ? 1'b1 : scl_pad_o) & ext_scl;
  assign sda_pad_i = (sda_padoen_o ? 1'b1 : sda_pad_o) & ext_sda;

  i2c_bit_engine dut (
    .wb_clk_i     (wb_clk_i),
    .arst_i       (arst_i),
    .ena          (ena),
    .clk_cnt      (clk_cnt),
    .cmd          (cmd),
    .cmd_valid    (cmd_valid),
    .din          (din),
    .cmd_ack      (cmd_ack),
    .dout         (dout),
    .busy         (busy),
    .al           (al),
    .scl_pad_i    (scl_pad_i),
    .scl_pad_o    (scl_pad_o),
    .scl_padoen_o (scl_padoen_o),
    .sda_pad_i    (sda_pad_i),
    .sda_pad_o    (sda_pad_o),
    .sda_padoen_o (sda_padoen_o)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Issue one primitive starting at a negedge; returns the number of negedges
  // until cmd_ack or al. mode 0: plain, 1: slave holds SCL low 50 cycles at
  // first SCL release, 2: another master pulls SDA low at first SCL release.
  task automatic do_cmd(input logic [2:0] c, input logic d, input int mode,
                        output int cnt, output logic ack_o, output logic al_o,
                        output logic fell_hi, output logic stable);
    logic prev_sda;
    logic armed;
    int   hold;
    cmd = c; din = d; cmd_valid = 1'b1;
    cnt = 0; ack_o = 1'b0; al_o = 1'b0; fell_hi = 1'b0; stable = 1'b1;
    prev_sda = sda_padoen_o; armed = 1'b0; hold = 0;
    for (int i = 0; i < 400 && !ack_o && !al_o; i++) begin
      @(negedge wb_clk_i);
      cnt++;
      if (cmd_ack) ack_o = 1'b1;
      if (al) al_o = 1'b1;
      if (prev_sda && !sda_padoen_o && scl_padoen_o) fell_hi = 1'b1;
      prev_sda = sda_padoen_o;
      if (scl_padoen_o && (sda_padoen_o !== d)) stable = 1'b0;
      if (hold > 0) begin
        hold--;
        if (hold == 0) ext_scl = 1'b1;
      end else if (!armed && scl_padoen_o && mode != 0) begin
        armed = 1'b1;
        if (mode == 1) begin ext_scl = 1'b0; hold = 50; end
        if (mode == 2) ext_sda = 1'b0;
      end
    end
    ext_scl = 1'b1;
    cmd_valid = 1'b0; cmd = NOP;
  endtask

  initial begin
    arst_i = 1'b0; ena = 1'b1; clk_cnt = 16'd4; cmd = NOP; cmd_valid = 1'b0; din = 1'b0;
    ext_scl = 1'b1; ext_sda = 1'b1;
    repeat (2) @(negedge wb_clk_i);
    chk("rst_cmd_ack", cmd_ack, 0);
    chk("rst_dout", dout, 0);
    chk("rst_busy", busy, 0);
    chk("rst_al", al, 0);
    chk("rst_scl_oen", scl_padoen_o, 1);
    chk("rst_sda_oen", sda_padoen_o, 1);
    chk("rst_scl_pad_o", scl_pad_o, 0);
    chk("rst_sda_pad_o", sda_pad_o, 0);
    arst_i = 1'b1;
    repeat (3) @(negedge wb_clk_i);

    // START then STOP at clk_cnt=4: 4*5 cycles + 1 entering phase A.
    do_cmd(START, 1'b0, 0, n, got_ack, got_al, sda_fell_hi, wr_stable);
    chk("start_ack", got_ack, 1);
    chk("start_latency", n, 21);
    chk("start_sda_fell_scl_hi", sda_fell_hi, 1);
    chk("start_busy", busy, 1);
    chk("start_scl_oen", scl_padoen_o, 0);
    chk("start_sda_oen", sda_padoen_o, 0);
    do_cmd(STOP, 1'b0, 0, n, got_ack, got_al, sda_fell_hi, wr_stable);
    chk("stop_ack", got_ack, 1);
    chk("stop_latency", n, 21);
    chk("stop_no_al", got_al, 0);
    chk("stop_busy", busy, 0);
    chk("stop_scl_oen", scl_padoen_o, 1);
    chk("stop_sda_oen", sda_padoen_o, 1);
    @(negedge wb_clk_i);
    chk("ack_one_cycle", cmd_ack, 0);

    // START + WRITE 1,0,1 at clk_cnt=2.
    clk_cnt = 16'd2;
    do_cmd(START, 1'b0, 0, n, got_ack, got_al, sda_fell_hi, wr_stable);
    chk("start2_latency", n, 13);
    do_cmd(WRITE, 1'b1, 0, n, got_ack, got_al, sda_fell_hi, wr_stable);
    chk("wr1_latency", n, 13);
    chk("wr1_sda_stable", wr_stable, 1);
    chk("wr1_sda_oen_end", sda_padoen_o, 1);
    do_cmd(WRITE, 1'b0, 0, n, got_ack, got_al, sda_fell_hi, wr_stable);
    chk("wr0_latency", n, 13);
    chk("wr0_sda_stable", wr_stable, 1);
    chk("wr0_sda_oen_end", sda_padoen_o, 0);
    do_cmd(WRITE, 1'b1, 0, n, got_ack, got_al, sda_fell_hi, wr_stable);
    chk("wr1b_latency", n, 13);
    chk("wr1b_sda_stable", wr_stable, 1);

    // Slave stretches SCL 50 cycles in phase B: ack delayed by exactly 50.
    do_cmd(WRITE, 1'b0, 1, n, got_ack, got_al, sda_fell_hi, wr_stable);
    chk("stretch_ack", got_ack, 1);
    chk("stretch_latency", n, 63);

    // Another master pulls SDA low while we release it in phase B.
    do_cmd(WRITE, 1'b1, 2, n, got_ack, got_al, sda_fell_hi, wr_stable);
    chk("arb_al", got_al, 1);
    chk("arb_no_ack", got_ack, 0);
    chk("arb_latency", n, 7);
    chk("arb_scl_oen", scl_padoen_o, 1);
    chk("arb_sda_oen", sda_padoen_o, 1);
    @(negedge wb_clk_i);
    chk("arb_al_one_cycle", al, 0);
    ack_seen = 1'b0;
    repeat (8) begin
      @(negedge wb_clk_i);
      if (cmd_ack) ack_seen = 1'b1;
    end
    chk("arb_no_late_ack", ack_seen, 0);
    ext_sda = 1'b1;
    repeat (5) @(negedge wb_clk_i);
    chk("arb_stop_busy", busy, 0);

    // READ with SDA held low by slave, then released.
    do_cmd(START, 1'b0, 0, n, got_ack, got_al, sda_fell_hi, wr_stable);
    chk("start3_busy", busy, 1);
    ext_sda = 1'b0;
    do_cmd(READ, 1'b0, 0, n, got_ack, got_al, sda_fell_hi, wr_stable);
    chk("rd0_latency", n, 13);
    chk("rd0_dout", dout, 0);
    ext_sda = 1'b1;
    do_cmd(READ, 1'b0, 0, n, got_ack, got_al, sda_fell_hi, wr_stable);
    chk("rd1_latency", n, 13);
    chk("rd1_dout", dout, 1);

    // Async reset in READ phase C.
    cmd = READ; din = 1'b0; cmd_valid = 1'b1;
    repeat (7) @(negedge wb_clk_i);
    chk("rdc_busy_before", busy, 1);
    chk("rdc_dout_before", dout, 1);
    arst_i = 1'b0;
    #1;
    chk("mid_rst_cmd_ack", cmd_ack, 0);
    chk("mid_rst_dout", dout, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_al", al, 0);
    chk("mid_rst_scl_oen", scl_padoen_o, 1);
    chk("mid_rst_sda_oen", sda_padoen_o, 1);
    cmd_valid = 1'b0; cmd = NOP;
    @(negedge wb_clk_i);
    arst_i = 1'b1;
    ack_seen = 1'b0;
    repeat (12) begin
      @(negedge wb_clk_i);
      if (cmd_ack) ack_seen = 1'b1;
    end
    chk("mid_rst_no_ack", ack_seen, 0);

    // Minimum prescale: one cycle per phase.
    clk_cnt = 16'd0;
    do_cmd(WRITE, 1'b1, 0, n, got_ack, got_al, sda_fell_hi, wr_stable);
    chk("cnt0_ack", got_ack, 1);
    chk("cnt0_latency", n, 5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
